// File: rtl/lc3_ctrl_pkg.sv
// Shared opcodes, controller state encoding and memory-phase codes for the LC3 pipeline controller.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12;

    typedef enum logic [1:0] {FILL, RUN, MEM, FLUSH} ctrl_state_e;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_IND   = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_IDLE  = 2'd3
    } mem_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/lc3_ctrl_hazard.sv
// ALU-to-ALU forwarding compare between the decode and execute instructions.
module lc3_ctrl_hazard
    import lc3_ctrl_pkg::*;
(
    input  logic        run_i,
    input  logic [15:0] ir_i,
    input  logic [15:0] ir_exec_i,
    output logic        bypass_1_o,
    output logic        bypass_2_o
);

    logic exec_alu;
    logic dec_alu;
    logic dec_reg_form;
    logic unused_ir;

    assign exec_alu     = is_alu_op(ir_exec_i[15:12]);
    assign dec_alu      = is_alu_op(ir_i[15:12]);
    // Only register-form ADD/AND read a second source register.
    assign dec_reg_form = ((ir_i[15:12] == OP_ADD) || (ir_i[15:12] == OP_AND)) && !ir_i[5];
    assign unused_ir    = ^{ir_i[4:3], ir_exec_i[8:0]};

    assign bypass_1_o = run_i && exec_alu && dec_alu && (ir_exec_i[11:9] == ir_i[8:6]);
    assign bypass_2_o = run_i && exec_alu && dec_reg_form && (ir_exec_i[11:9] == ir_i[2:0]);

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC3 pipeline controller: stage enables, memory phases, branch redirect/flush.
// Optional ALU forwarding compare enabled by defining LC3_CTRL_BYPASS_EN.
//
// state | meaning
// FILL  | pipeline ramp-up after reset, one more stage enabled per cycle
// RUN   | all stages enabled, execute-stage opcode decoded each cycle
// MEM   | data-memory phases in progress, all stages held
// FLUSH | bubbles after a taken branch, only PC/fetch enabled
module lc3_pipe_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_exec,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2
);

    ctrl_state_e state_q, state_d;
    mem_state_e  mem_state_q, mem_state_d;
    mem_state_e  mem_next_q, mem_next_d;
    logic [1:0]  fill_cnt_q, fill_cnt_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        suppress_q, suppress_d;

    logic [3:0]  opcode;
    logic        is_mem_op;
    logic        is_branch;
    logic        decide_en;
    logic        br_taken_c;
    logic [4:0]  en_base;
    logic [4:0]  en_out;

    assign opcode    = IR_exec[15:12];
    assign is_mem_op = (opcode == OP_LD)  || (opcode == OP_LDR) || (opcode == OP_LDI) ||
                       (opcode == OP_ST)  || (opcode == OP_STR) || (opcode == OP_STI);
    assign is_branch = ((opcode == OP_BR) && ((IR_exec[11:9] & psr) != 3'b000)) ||
                       (opcode == OP_JMP);
    // The first RUN cycle after MEM/FLUSH still sees the instruction already handled.
    assign decide_en = complete_instr &&
                       (((state_q == RUN) && !suppress_q) ||
                        ((state_q == FILL) && (fill_cnt_q == 2'd3)));

    always_comb begin
        state_d     = state_q;
        mem_state_d = mem_state_q;
        mem_next_d  = mem_next_q;
        fill_cnt_d  = fill_cnt_q;
        flush_cnt_d = flush_cnt_q;
        suppress_d  = suppress_q;
        en_base     = 5'b00000;
        br_taken_c  = 1'b0;

        case (state_q)
            FILL: begin
                en_base = {2'b11, fill_cnt_q != 2'd0, fill_cnt_q >= 2'd2, fill_cnt_q == 2'd3};
                if (complete_instr) begin
                    if (fill_cnt_q == 2'd3) state_d    = RUN;
                    else                    fill_cnt_d = fill_cnt_q + 2'd1;
                end
            end
            RUN: begin
                en_base = 5'b11111;
                if (complete_instr) suppress_d = 1'b0;
            end
            MEM: begin
                if (complete_data) begin
                    mem_state_d = mem_next_q;
                    mem_next_d  = MEM_IDLE;
                    if (mem_next_q == MEM_IDLE) begin
                        state_d    = RUN;
                        suppress_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                en_base = 5'b11000;
                if (complete_instr) begin
                    if (flush_cnt_q == 2'd0) begin
                        state_d    = RUN;
                        suppress_d = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (decide_en) begin
            if (is_mem_op) begin
                state_d = MEM;
                case (opcode)
                    OP_LDI: begin mem_state_d = MEM_IND;   mem_next_d = MEM_READ;  end
                    OP_STI: begin mem_state_d = MEM_IND;   mem_next_d = MEM_WRITE; end
                    OP_ST,
                    OP_STR: begin mem_state_d = MEM_WRITE; mem_next_d = MEM_IDLE;  end
                    default: begin mem_state_d = MEM_READ; mem_next_d = MEM_IDLE;  end
                endcase
            end else if (is_branch) begin
                state_d     = FLUSH;
                flush_cnt_d = 2'(FLUSH_CYCLES - 1);
                br_taken_c  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            mem_state_q <= MEM_IDLE;
            mem_next_q  <= MEM_IDLE;
            fill_cnt_q  <= 2'd0;
            flush_cnt_q <= 2'd0;
            suppress_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_state_q <= mem_state_d;
            mem_next_q  <= mem_next_d;
            fill_cnt_q  <= fill_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            suppress_q  <= suppress_d;
        end
    end

    // Reset holding low masks the FILL cnt-0 enables as well.
    assign en_out = en_base & {5{complete_instr & reset}};
    assign {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback} = en_out;
    assign br_taken  = br_taken_c & reset;
    assign mem_state = mem_state_q;

`ifdef LC3_CTRL_BYPASS_EN
    lc3_ctrl_hazard u_hazard (
        .run_i      ((state_q == RUN) && reset),
        .ir_i       (IR),
        .ir_exec_i  (IR_exec),
        .bypass_1_o (bypass_alu_1),
        .bypass_2_o (bypass_alu_2)
    );
    logic unused_top;
    assign unused_top = 1'b0;
`else
    logic unused_top;
    assign unused_top   = ^{IR, IR_exec[8:0]};
    assign bypass_alu_1 = 1'b0;
    assign bypass_alu_2 = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Scoreboard bench for lc3_pipe_controller: directed per-cycle vectors, monitor compares at negedge.
module tb_lc3_pipe_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        complete_instr = 1'b0;
    logic        complete_data = 1'b0;
    logic [15:0] IR = 16'h0000;
    logic [15:0] IR_exec = 16'h1000;
    logic [2:0]  psr = 3'b000;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        bypass_alu_1, bypass_alu_2;

    lc3_pipe_controller #(.FLUSH_CYCLES(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IR               (IR),
        .IR_exec          (IR_exec),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .mem_state        (mem_state),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2)
    );

    always #5 clock = ~clock;

`ifdef LC3_CTRL_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    localparam logic [15:0] NOP   = 16'h1000;  // ADD R0,R0,R0
    localparam logic [15:0] LDI_I = 16'hA000;
    localparam logic [15:0] ST_I  = 16'h3000;
    localparam logic [15:0] STR_I = 16'h7000;
    localparam logic [15:0] BRZ   = 16'h0400;
    localparam logic [15:0] JMP_I = 16'hC1C0;
    localparam logic [15:0] ADD3  = 16'h1642;  // ADD R3,R1,R2
    localparam logic [15:0] AND_R = 16'h58C3;  // AND R4,R3,R3
    localparam logic [15:0] AND_I = 16'h58E3;  // AND R4,R3,#3

    logic [9:0] exp_q[$];
    string      name_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic step(input logic ci, input logic cd, input logic rst,
                        input logic [15:0] ir_v, input logic [15:0] irx_v, input logic [2:0] psr_v,
                        input logic [4:0] en, input logic br, input logic [1:0] ms,
                        input logic b1, input logic b2, input string nm);
        @(posedge clock);
        #1;
        complete_instr = ci;
        complete_data  = cd;
        reset          = rst;
        IR             = ir_v;
        IR_exec        = irx_v;
        psr            = psr_v;
        exp_q.push_back({en, br, ms, b1, b2});
        name_q.push_back(nm);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            logic [9:0] a;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
                  br_taken, mem_state, bypass_alu_1, bypass_alu_2};
            n_total = n_total + 1;
            if (a === e) n_pass = n_pass + 1;
            else $display("FAIL %s: got en=%b br=%b ms=%0d byp=%b, want en=%b br=%b ms=%0d byp=%b",
                          nm, a[9:5], a[4], a[3:2], a[1:0], e[9:5], e[4], e[3:2], e[1:0]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        // reset held, then FILL ramp
        step(1, 0, 0, 16'h0, NOP, 3'b000, 5'b00000, 0, 2'd3, 0, 0, "reset");
        step(1, 0, 1, 16'h0, NOP, 3'b000, 5'b11000, 0, 2'd3, 0, 0, "fill0");
        step(1, 0, 1, 16'h0, NOP, 3'b000, 5'b11100, 0, 2'd3, 0, 0, "fill1");
        step(1, 0, 1, 16'h0, NOP, 3'b000, 5'b11110, 0, 2'd3, 0, 0, "fill2");
        step(1, 0, 1, 16'h0, NOP, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "fill3");
        step(1, 0, 1, 16'h0, NOP, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "run4");
        step(1, 0, 1, 16'h0, NOP, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "run5");

        // LDI: two phases, complete_data after 2 low cycles each
        step(1, 0, 1, 16'h0, LDI_I, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "ldi_issue");
        step(1, 0, 1, 16'h0, LDI_I, 3'b000, 5'b00000, 0, 2'd1, 0, 0, "ldi_ind_a");
        step(1, 0, 1, 16'h0, LDI_I, 3'b000, 5'b00000, 0, 2'd1, 0, 0, "ldi_ind_b");
        step(1, 1, 1, 16'h0, LDI_I, 3'b000, 5'b00000, 0, 2'd1, 0, 0, "ldi_ind_c");
        step(1, 0, 1, 16'h0, LDI_I, 3'b000, 5'b00000, 0, 2'd0, 0, 0, "ldi_rd_a");
        step(1, 0, 1, 16'h0, LDI_I, 3'b000, 5'b00000, 0, 2'd0, 0, 0, "ldi_rd_b");
        step(1, 1, 1, 16'h0, LDI_I, 3'b000, 5'b00000, 0, 2'd0, 0, 0, "ldi_rd_c");
        step(1, 0, 1, 16'h0, LDI_I, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "ldi_suppr");
        step(1, 0, 1, 16'h0, NOP,   3'b000, 5'b11111, 0, 2'd3, 0, 0, "ldi_noretrig");

        // ST with complete_data already high on MEM entry
        step(1, 0, 1, 16'h0, ST_I, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "st_issue");
        step(1, 1, 1, 16'h0, ST_I, 3'b000, 5'b00000, 0, 2'd2, 0, 0, "st_wr_1cyc");
        step(1, 0, 1, 16'h0, ST_I, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "st_suppr");
        step(1, 0, 1, 16'h0, NOP,  3'b000, 5'b11111, 0, 2'd3, 0, 0, "st_after");

        // BRz taken, then flush
        step(1, 0, 1, 16'h0, BRZ, 3'b010, 5'b11111, 1, 2'd3, 0, 0, "brz_taken");
        step(1, 0, 1, 16'h0, BRZ, 3'b010, 5'b11000, 0, 2'd3, 0, 0, "flush_a");
        step(1, 0, 1, 16'h0, BRZ, 3'b010, 5'b11000, 0, 2'd3, 0, 0, "flush_b");
        step(1, 0, 1, 16'h0, BRZ, 3'b010, 5'b11111, 0, 2'd3, 0, 0, "brz_suppr");
        step(1, 0, 1, 16'h0, NOP, 3'b010, 5'b11111, 0, 2'd3, 0, 0, "brz_after");

        // BRz not taken
        step(1, 0, 1, 16'h0, BRZ, 3'b100, 5'b11111, 0, 2'd3, 0, 0, "brz_nt_a");
        step(1, 0, 1, 16'h0, BRZ, 3'b100, 5'b11111, 0, 2'd3, 0, 0, "brz_nt_b");

        // JMP
        step(1, 0, 1, 16'h0, JMP_I, 3'b000, 5'b11111, 1, 2'd3, 0, 0, "jmp_taken");
        step(1, 0, 1, 16'h0, JMP_I, 3'b000, 5'b11000, 0, 2'd3, 0, 0, "jmp_flush_a");
        step(1, 0, 1, 16'h0, JMP_I, 3'b000, 5'b11000, 0, 2'd3, 0, 0, "jmp_flush_b");
        step(1, 0, 1, 16'h0, NOP,   3'b000, 5'b11111, 0, 2'd3, 0, 0, "jmp_run");

        // instruction stall during a taken branch
        step(0, 0, 1, 16'h0, BRZ, 3'b010, 5'b00000, 0, 2'd3, 0, 0, "stall_a");
        step(0, 0, 1, 16'h0, BRZ, 3'b010, 5'b00000, 0, 2'd3, 0, 0, "stall_b");
        step(0, 0, 1, 16'h0, BRZ, 3'b010, 5'b00000, 0, 2'd3, 0, 0, "stall_c");
        step(1, 0, 1, 16'h0, BRZ, 3'b010, 5'b11111, 1, 2'd3, 0, 0, "stall_redirect");
        step(1, 0, 1, 16'h0, BRZ, 3'b010, 5'b11000, 0, 2'd3, 0, 0, "stall_flush_a");
        step(1, 0, 1, 16'h0, BRZ, 3'b010, 5'b11000, 0, 2'd3, 0, 0, "stall_flush_b");
        step(1, 0, 1, 16'h0, NOP, 3'b010, 5'b11111, 0, 2'd3, 0, 0, "stall_run");

        // reset in the middle of a write phase
        step(1, 0, 1, 16'h0, STR_I, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "str_issue");
        step(1, 0, 1, 16'h0, STR_I, 3'b000, 5'b00000, 0, 2'd2, 0, 0, "str_wr");
        step(1, 0, 0, 16'h0, STR_I, 3'b000, 5'b00000, 0, 2'd3, 0, 0, "midmem_reset");
        step(1, 0, 0, 16'h0, STR_I, 3'b000, 5'b00000, 0, 2'd3, 0, 0, "reset_hold");
        step(1, 0, 1, 16'h0, NOP,   3'b000, 5'b11000, 0, 2'd3, 0, 0, "refill0");
        step(1, 0, 1, 16'h0, NOP,   3'b000, 5'b11100, 0, 2'd3, 0, 0, "refill1");
        step(1, 0, 1, 16'h0, NOP,   3'b000, 5'b11110, 0, 2'd3, 0, 0, "refill2");
        // JMP arriving exactly at fill count 3 is decided there
        step(1, 0, 1, 16'h0, JMP_I, 3'b000, 5'b11111, 1, 2'd3, 0, 0, "refill3_jmp");
        step(1, 0, 1, 16'h0, JMP_I, 3'b000, 5'b11000, 0, 2'd3, 0, 0, "refill_flush_a");
        step(1, 0, 1, 16'h0, JMP_I, 3'b000, 5'b11000, 0, 2'd3, 0, 0, "refill_flush_b");
        step(1, 0, 1, 16'h0, JMP_I, 3'b000, 5'b11111, 0, 2'd3, 0, 0, "refill_suppr");

        // forwarding compare
        step(1, 0, 1, AND_R, ADD3, 3'b000, 5'b11111, 0, 2'd3, BYP, BYP,  "bypass_reg");
        step(1, 0, 1, AND_I, ADD3, 3'b000, 5'b11111, 0, 2'd3, BYP, 1'b0, "bypass_imm");
        step(1, 0, 1, 16'h0, NOP,  3'b000, 5'b11111, 0, 2'd3, 0, 0, "bypass_none");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            n_total = n_total + 1;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lc3_pipe_controller.md
# lc3_pipe_controller

Pipeline controller for the LC3 core. It sequences the fetch, decode, execute and writeback stages through their stage enables, and stalls them for data-memory phases. It detects taken BR/JMP in the execute stage, drives the PC redirect, and flushes the younger stages. It sits beside the execute stage and consumes the same `IR_exec` bus that the execute_out agent monitors.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: bubble cycles after a taken branch (legal range 1–3).

Ports:
- `clock` — input, 1 — sole clock; all state changes on the rising edge.
- `reset` — input, 1 — asynchronous, active-low.
- `complete_instr` — input, 1 — instruction memory has returned the current fetch.
- `complete_data` — input, 1 — data memory has completed the current phase.
- `IR` — input, 16 — instruction in the decode stage.
- `IR_exec` — input, 16 — instruction in the execute stage.
- `psr` — input, 3 — current NZP condition codes.
- `enable_updatePC`, `enable_fetch`, `enable_decode`, `enable_execute`, `enable_writeback` — output, 1 each — stage enables.
- `br_taken` — output, 1 — PC loads the branch target.
- `mem_state` — output, 2 — memory phase:
  - 0 = read
  - 1 = indirect read
  - 2 = write
  - 3 = idle
- `bypass_alu_1`, `bypass_alu_2` — output, 1 each — forward `aluout` to the execute operand 1 / operand 2.

## Operation
- States: FILL, RUN, MEM, FLUSH.
- Reset (`reset` = 0, asynchronous):
  - State = FILL, `fill_cnt` = 0.
  - All enables 0, `br_taken` 0, bypasses 0, `mem_state` = 3.
- FILL: `fill_cnt` increments each cycle. Enables ramp as follows, then the controller moves to RUN:
  - cnt 0: updatePC and fetch.
  - cnt 1: adds decode.
  - cnt 2: adds execute.
  - cnt 3: adds writeback.
- RUN: all five enables are 1. Opcode is `IR_exec[15:12]`, and decisions are evaluated each cycle. The same decisions are also evaluated in FILL at cnt 3.
  - LD (2), LDR (6), LDI (10), ST (3), STR (7), STI (11): go to MEM.
  - BR (0) with `(IR_exec[11:9] & psr) != 0`, or JMP (12): `br_taken` = 1 in the current cycle, then go to FLUSH.
  - Anything else: stay in RUN.
- Decision suppression: evaluation is suppressed in the first RUN cycle after MEM or FLUSH, because `IR_exec` still holds the already-handled instruction.
- Stall: `complete_instr` = 0 in FILL/RUN/FLUSH forces all enables to 0 combinationally.
  - State, `fill_cnt` and the flush counter hold.
  - `br_taken` is forced to 0 and no decision is taken.
- MEM: all enables are 0. Phase sequences:
  - LD/LDR: read (0).
  - ST/STR: write (2).
  - LDI: indirect read (1), then read (0).
  - STI: indirect read (1), then write (2).
  - Each phase ends at the edge where `complete_data` = 1. The last phase returns to RUN with `mem_state` = 3.
  - `complete_instr` is ignored in MEM.
- FLUSH: for `FLUSH_CYCLES` cycles, updatePC and fetch are 1; decode, execute and writeback are 0. Then go to RUN.
- Priority: reset > instruction stall > memory op > branch.
- Mid-operation reset in any state returns to the reset values immediately; no memory phase is resumed.

## Timing
- Enables and `mem_state` are Moore outputs of state. The only combinational input dependencies are:
  - the `complete_instr` gating;
  - `br_taken` (from `IR_exec`/`psr`);
  - the bypasses (from `IR`/`IR_exec`).
- Memory latency: a load/store occupies 1 + N cycles of MEM per phase, where N is the number of cycles `complete_data` stays low.
- Branch penalty: 1 redirect cycle plus `FLUSH_CYCLES`.
- `complete_data` asserted in the same cycle MEM is entered is honoured; that phase lasts 1 cycle.

## Configuration
- `LC3_CTRL_BYPASS_EN` defined: the bypasses are live, but only in RUN.
  - `bypass_alu_1` = 1 when `IR_exec` is ADD/AND/NOT, `IR` is ADD/AND/NOT, and `IR_exec[11:9] == IR[8:6]`.
  - `bypass_alu_2` = 1 when `IR_exec` is ADD/AND/NOT, `IR` is ADD/AND with `IR[5]` = 0, and `IR_exec[11:9] == IR[2:0]`.
- Undefined: both bypass ports are present and tied to 0.

## Structure
- `lc3_ctrl_pkg` holds:
  - opcode constants;
  - the state enum {FILL, RUN, MEM, FLUSH};
  - the `mem_state` codes MEM_READ, MEM_IND, MEM_WRITE, MEM_IDLE.
- Sub-module `lc3_ctrl_hazard` holds the bypass compare logic and is instantiated only under `LC3_CTRL_BYPASS_EN`.

## Test plan
- Reset release, `complete_instr` = 1, NOPs (ADD) only -> enables ramp over 4 cycles exactly as listed under FILL; RUN all-ones from cycle 4; `mem_state` = 3.
- LDI x2000 in execute, `complete_data` high after 2 cycles in each phase -> `mem_state` sequence 1,1,1,0,0,0,3; enables 0 for 6 cycles; no retrigger in the next cycle.
- BRz with `psr` = 3'b010 -> `br_taken` = 1 for one cycle, then 2 cycles with decode/execute/writeback 0; with `psr` = 3'b100 -> no redirect, enables stay 1.
- `complete_instr` low for 3 cycles during a taken-BR cycle -> enables 0 and `br_taken` 0 while low; redirect occurs on the first cycle it is high.
- `reset` asserted mid-MEM (`mem_state` = 2) -> same-cycle return to `mem_state` 3 and all enables 0; FILL restarts at release.
- Bypass build: `IR_exec` = ADD R3,R1,R2 with `IR` = AND R4,R3,R3 -> `bypass_alu_1` = `bypass_alu_2` = 1; non-bypass build -> both 0.
